mem_block_responder: RTL

MEM_BLOCK_RESPONDER -- requirements
Module: mem_block_responder

---
 rtl/mem_block_responder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_block_responder.sv
// mem_block_responder
//   Fixed-latency 128-bit block memory responder. A request is accepted in
//   IDLE and answered with a one-cycle ready pulse LATENCY edges later. The
//   responder then spends one TURN cycle ignoring the requester before it
//   returns to IDLE. When valid drops during BUSY the request is aborted,
//   with no write and no ready pulse.
//
//   Optional feature (macro MEM_BLOCK_RESPONDER_RANGE_CHECK_EN):
//     When defined, addresses with nonzero bits above the array range raise
//     Err during RESP. Such writes are dropped and such reads return zero.
//     When undefined, upper address bits are ignored and the address wraps.
//
// Ports
//   CLK       in   1    clock, rising edge
//   RST       in   1    asynchronous active-low reset
//   Request   in   162  [31:0] byte addr, [32] valid, [33] 1=write, [161:34] data
//   Response  out  129  [0] ready, [128:1] block data (held between responses)
//   Err       out  1    address-range error, only ever high with ready
module mem_block_responder #(
    parameter int unsigned LATENCY    = 16,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [161:0] Request,
    output logic [128:0] Response,
    output logic         Err
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);
    localparam bit          DIRECT   = (LATENCY == 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, TURN} state_t;

    state_t       state;
    logic [7:0]   count;
    logic [31:0]  lat_addr;
    logic         lat_wr;
    logic [127:0] lat_data;

    // Zero at time zero; deliberately untouched by reset.
    logic [127:0] mem [DEPTH] = '{default: '0};

    logic [31:0]  req_addr;
    logic         req_valid;
    logic         req_wr;
    logic [127:0] req_data;

    assign req_addr  = Request[31:0];
    assign req_valid = Request[32];
    assign req_wr    = Request[33];
    assign req_data  = Request[161:34];

    // Transaction fields used on the edge that enters RESP. They normally
    // come from the latched copy. With LATENCY=1 the accepting edge is also
    // the RESP-entry edge, so they come straight from Request.
    logic                  enter_resp;
    logic [31:0]           t_addr;
    logic                  t_wr;
    logic [127:0]          t_data;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  oob;
    logic [127:0]          resp_data;

    always_comb begin
        enter_resp = 1'b0;
        t_addr     = lat_addr;
        t_wr       = lat_wr;
        t_data     = lat_data;
        case (state)
            IDLE: begin
                if (DIRECT && req_valid) begin
                    enter_resp = 1'b1;
                    t_addr     = req_addr;
                    t_wr       = req_wr;
                    t_data     = req_data;
                end
            end
            BUSY: begin
                if (req_valid && count == '0) begin
                    enter_resp = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign idx = t_addr[DEPTH_LOG2+3:4];

`ifdef MEM_BLOCK_RESPONDER_RANGE_CHECK_EN
    assign oob = (t_addr >> (DEPTH_LOG2 + 4)) != '0;
`else
    assign oob = 1'b0;
`endif

    // Address bits outside the index field matter only to the range check.
    logic unused_addr_bits;
    assign unused_addr_bits = ^t_addr;

    assign resp_data = t_wr ? t_data : (oob ? '0 : mem[idx]);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            count    <= '0;
            lat_addr <= '0;
            lat_wr   <= 1'b0;
            lat_data <= '0;
            Response <= '0;
            Err      <= 1'b0;
        end else begin
            // Ready and Err last one cycle. The data field holds its value.
            Response[0] <= 1'b0;
            Err         <= 1'b0;

            if (state == IDLE && req_valid) begin
                lat_addr <= req_addr;
                lat_wr   <= req_wr;
                lat_data <= req_data;
            end

            if (enter_resp) begin
                state    <= RESP;
                count    <= '0;
                Response <= {resp_data, 1'b1};
                Err      <= oob;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid) begin
                            count <= CNT_LOAD;
                            state <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (!req_valid) begin
                            state <= IDLE;
                            count <= '0;
                        end else begin
                            count <= count - 8'd1;
                        end
                    end
                    RESP:    state <= TURN;
                    TURN:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // A reset in progress forces state to IDLE asynchronously, so no commit
    // can happen. The RST term keeps this port quiet on the reset edge.
    always_ff @(posedge CLK) begin
        if (RST && enter_resp && t_wr && !oob) begin
            mem[idx] <= t_data;
        end
    end

endmodule
